seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, sequential successor to the 4-bit combinational ALU: WIDTH-bit operands, eight operations including add-with-carry, a barrel-free iterative left shift and an iterative shift-add multiply. It adds an accumulator register, persistent flags and valid/ready handshakes on both sides. It sits between the operand/command front-end and the result sink in the ALU datapath.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥ 4
- SHW, $clog2(WIDTH), derived localparam: shift-amount width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SHL, 111 MUL
- use_acc  in  1  1: operand A is the accumulator; a is ignored
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; SHL uses b[SHW-1:0] as the shift count
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- result  out  WIDTH  result
- flag_c, flag_z, flag_s, flag_v  out  1 each  carry/borrow, zero, sign, signed overflow
- busy  out  1  high in EXEC

## Operation
- State machine with states IDLE, EXEC and DONE.
  - IDLE: in_ready = 1. On accept, latch op and operands.
    - ADD, SUB, AND, OR, XOR, ADC, and SHL with count 0 → DONE.
    - SHL with count n > 0, or MUL → EXEC.
  - EXEC: one step per cycle. SHL runs n steps; MUL runs WIDTH steps (shift-add, LSB of multiplier first). → DONE after the last step.
  - DONE: out_valid = 1. result and flags are stable until the handshake. On out_ready → IDLE.
- in_ready = (state == IDLE), combinational. in_valid is ignored outside IDLE.
- Arithmetic is modulo 2^WIDTH.
  - ADD: flag_c is the carry out.
  - SUB: flag_c is the borrow (a < b unsigned).
  - ADC: a + b + stored flag_c.
- flag_v is two's-complement overflow for ADD, SUB and ADC. It is 0 for all other ops.
- flag_c for the other ops:
  - SHL: last bit shifted out; 0 when the count is 0.
  - MUL: 1 if the upper WIDTH bits of the 2·WIDTH-bit product are non-zero.
  - Logic ops: 0.
- flag_z = (result == 0). flag_s = result[WIDTH-1].
- Accumulator and all flags update once, on the cycle the op completes (entry to DONE). They persist until the next completion. ADC consumes the stored carry.
- The accumulator is internal and observable only through use_acc.

## Timing
- Reset: state IDLE, in_ready = 1, out_valid = 0, busy = 0. result, accumulator and all flags = 0.
- Latency, counted from the accept edge to out_valid high:
  - 1 cycle for single-cycle ops and SHL with count 0.
  - n + 1 cycles for SHL with count n.
  - WIDTH + 1 cycles for MUL.
- Peak throughput for single-cycle ops is one op per 2 cycles (accept in IDLE, deliver in DONE).
- out_ready held low: DONE is held indefinitely and no new command is accepted.
- out_ready high while not in DONE: no effect.
- rst asserted mid-EXEC or in DONE: the op is aborted, no result is delivered, and the accumulator and flags are cleared.
- Reset is applied asynchronously. Deassertion takes effect at the next clk edge.

## Structure
- Package alu_pkg holds:
  - op_e enum (3-bit encodings above)
  - state_e enum (IDLE, EXEC, DONE)
  - flags_t packed struct {c, z, s, v}
- Sub-module alu_core: purely combinational single-cycle ops (ADD/SUB/ADC/logic) plus flag generation, parametrised on WIDTH.
- The top level owns the FSM, step counter, SHL/MUL iteration registers, accumulator and flag registers.

## Test plan
All scenarios use WIDTH = 8.
- **ADD:** 0xF0 + 0x20 → result 0x10, C=1, Z=0, S=0, V=0; out_valid 1 cycle after accept.
- **SUB then ADC:** SUB 0x05 − 0x07 → 0xFE, C=1, S=1. Then ADC 0x01 + 0x01 → 0x03, C=0.
- **Overflow:** SUB 0x80 − 0x01 → 0x7F, V=1. ADD 0x7F + 0x01 → 0x80, V=1, S=1. AND 0x0F & 0xF0 → 0x00, Z=1, V=0.
- **MUL:** 0x13 × 0x11 → 0x43, C=1; out_valid 9 cycles after accept; busy high and in_ready low throughout.
- **SHL:** 0x81 by count 1 → 0x02, C=1, latency 2. 0x81 by count 0 → 0x81, C=0, latency 1.
- **Accumulator, backpressure, reset:**
  - ADD 0x10 + 0x05; then ADD with use_acc=1, b=0x01 → 0x16.
  - Hold out_ready low for 5 cycles: result and flags are stable and in_ready stays 0.
  - Assert rst during MUL EXEC: out_valid never rises, all outputs return to reset values, and the next use_acc ADD with b=0x02 → 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and state encodings, flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic s;
        logic v;
    } flags_t;

    // MUL always iterates; SHL iterates only for a non-zero count.
    function automatic logic needs_exec(input op_e op, input logic shamt_nonzero);
        return (op == OP_MUL) || ((op == OP_SHL) && shamt_nonzero);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Command/result handshake bundle between the operand front-end and the result sink.
interface seq_alu_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             use_acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_s;
    logic             flag_v;
    logic             busy;

    // Front-end / sink side.
    modport master (
        output in_valid, op, use_acc, a, b, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_s, flag_v, busy
    );

    // ALU side.
    modport slave (
        input  in_valid, op, use_acc, a, b, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_s, flag_v, busy
    );

endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops (ADD/SUB/ADC/AND/OR/XOR) with flag generation.
// SHL/MUL pass operand A through with C=V=0, which is exactly the SHL-by-zero result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags
);

    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    assign w_cin  = (i_op == OP_ADC) ? i_cin : 1'b0;
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Select the op result, carry/borrow and signed overflow, then derive Z and S.
    always_comb begin
        o_result  = i_a;
        o_flags   = '0;
        case (i_op)
            OP_ADD, OP_ADC: begin
                o_result  = w_sum[WIDTH-1:0];
                o_flags.c = w_sum[WIDTH];
                o_flags.v = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result  = w_diff[WIDTH-1:0];
                o_flags.c = w_diff[WIDTH];
                o_flags.v = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: o_result = i_a;
        endcase
        o_flags.z = (o_result == '0);
        o_flags.s = o_result[WIDTH-1];
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: handshaked command in, handshaked result out, with accumulator,
// persistent flags, iterative SHL and shift-add MUL.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;

    state_e             r_state;
    state_e             w_next;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_accept;
    logic               w_iter;
    logic               w_last;

    op_e                w_op;
    logic [WIDTH-1:0]   w_opa;
    logic [SHW-1:0]     w_shamt;

    op_e                r_op;
    logic [WIDTH-1:0]   r_opa;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_acc;
    flags_t             r_flags;

    logic [WIDTH-1:0]   w_core_res;
    flags_t             w_core_flags;
    logic [WIDTH:0]     w_mul_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_shl_next;
    logic [WIDTH-1:0]   w_exec_res;
    flags_t             w_exec_flags;

    assign w_op    = op_e'(bus.op);
    assign w_opa   = bus.use_acc ? r_acc : bus.a;
    assign w_shamt = bus.b[SHW-1:0];
    assign w_iter  = needs_exec(w_op, w_shamt != '0);
    assign w_last  = (r_cnt == CNTW'(1));

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op     (w_op),
        .i_a      (w_opa),
        .i_b      (bus.b),
        .i_cin    (r_flags.c),
        .o_result (w_core_res),
        .o_flags  (w_core_flags)
    );

    // One shift-add step: upper half accumulates the multiplicand when the
    // current multiplier LSB is set, then the whole product shifts right.
    assign w_mul_add  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                        (r_prod[0] ? {1'b0, r_opa} : '0);
    assign w_mul_next = {w_mul_add, r_prod[WIDTH-1:1]};
    assign w_shl_next = {r_opa[WIDTH-2:0], 1'b0};

    // Result and flags of the final EXEC step, committed when w_last is set.
    always_comb begin
        w_exec_flags = '0;
        if (r_op == OP_MUL) begin
            w_exec_res     = w_mul_next[WIDTH-1:0];
            w_exec_flags.c = |w_mul_next[2*WIDTH-1:WIDTH];
        end else begin
            w_exec_res     = w_shl_next;
            w_exec_flags.c = r_opa[WIDTH-1];
        end
        w_exec_flags.z = (w_exec_res == '0);
        w_exec_flags.s = w_exec_res[WIDTH-1];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_iter ? EXEC : DONE;
                end
            end
            EXEC: begin
                w_busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, iteration registers, accumulator and flag commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= OP_ADD;
            r_opa   <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_flags <= '0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_opa  <= w_opa;
            r_prod <= {{WIDTH{1'b0}}, bus.b};
            r_cnt  <= (w_op == OP_MUL) ? CNTW'(WIDTH) : {1'b0, w_shamt};
            if (!w_iter) begin
                r_acc   <= w_core_res;
                r_flags <= w_core_flags;
            end
        end else if (r_state == EXEC) begin
            r_cnt <= r_cnt - CNTW'(1);
            if (r_op == OP_SHL) r_opa  <= w_shl_next;
            else                r_prod <= w_mul_next;
            if (w_last) begin
                r_acc   <= w_exec_res;
                r_flags <= w_exec_flags;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.result    = r_acc;
    assign bus.flag_c    = r_flags.c;
    assign bus.flag_z    = r_flags.z;
    assign bus.flag_s    = r_flags.s;
    assign bus.flag_v    = r_flags.v;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

    localparam int WIDTH = 8;
    localparam int MASK  = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference architectural state.
    int m_acc = 0;
    int m_c   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic int ovf(input int x);
        return (x < -128 || x > 127) ? 1 : 0;
    endfunction

    // Compute the expected outcome of one op and advance the model state.
    task automatic model(input int op, input int ua, input int a, input int b,
                         output int res, output int c, output int v, output int lat);
        int A;
        int full;
        int n;
        A   = ua ? m_acc : a;
        lat = 1;
        c   = 0;
        v   = 0;
        res = 0;
        case (op)
            0: begin full = A + b; res = full & MASK; c = (full > MASK); v = ovf(sx(A) + sx(b)); end
            1: begin res = (A - b) & MASK; c = (A < b); v = ovf(sx(A) - sx(b)); end
            2: res = A & b;
            3: res = A | b;
            4: res = A ^ b;
            5: begin full = A + b + m_c; res = full & MASK; c = (full > MASK); v = ovf(sx(A) + sx(b) + m_c); end
            6: begin
                n   = b % 8;
                res = (A << n) & MASK;
                c   = (n > 0) ? ((A >> (8 - n)) & 1) : 0;
                lat = n + 1;
            end
            default: begin
                full = A * b;
                res  = full & MASK;
                c    = ((full >> 8) != 0);
                lat  = WIDTH + 1;
            end
        endcase
        m_acc = res;
        m_c   = c;
    endtask

    task automatic do_op(input int op, input int ua, input int a, input int b, input int hold);
        int e_res, e_c, e_v, e_lat;
        int lat;
        bit done;
        model(op, ua, a, b, e_res, e_c, e_v, e_lat);
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = op[2:0];
        bus.use_acc   = ua[0];
        bus.a         = a[7:0];
        bus.b         = b[7:0];
        lat  = 0;
        done = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.in_valid = 1'b0;
                bus.a        = 8'($urandom);
                bus.b        = 8'($urandom);
            end
            if (bus.out_valid) begin
                done = 1;
            end else begin
                check("busy_exec", bus.busy, 1);
                check("in_ready_exec", bus.in_ready, 0);
                if (hold == 0) bus.out_ready = 1'($urandom);
            end
        end
        check("latency", lat, e_lat);
        check("result", bus.result, e_res);
        check("flag_c", bus.flag_c, e_c);
        check("flag_z", bus.flag_z, (e_res == 0));
        check("flag_s", bus.flag_s, (e_res >> 7) & 1);
        check("flag_v", bus.flag_v, e_v);
        check("busy_done", bus.busy, 0);
        check("in_ready_done", bus.in_ready, 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 3'($urandom);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_result", bus.result, e_res);
            check("hold_flag_c", bus.flag_c, e_c);
            check("hold_flag_v", bus.flag_v, e_v);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("consumed_valid", bus.out_valid, 0);
        check("consumed_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_flags"}, {bus.flag_c, bus.flag_z, bus.flag_s, bus.flag_v}, 0);
    endtask

    task automatic reset_mid_mul();
        bit seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 3'b111;
        bus.use_acc  = 1'b0;
        bus.a        = 8'h37;
        bus.b        = 8'hC5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        m_acc = 0;
        m_c   = 0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("rst_no_result", seen, 0);
        check_reset_outputs("rst_after");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 3'b000;
        bus.use_acc   = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        do_op(0, 0, 8'hF0, 8'h20, 0);
        do_op(1, 0, 8'h05, 8'h07, 0);
        do_op(5, 0, 8'h01, 8'h01, 0);
        do_op(1, 0, 8'h80, 8'h01, 0);
        do_op(0, 0, 8'h7F, 8'h01, 0);
        do_op(2, 0, 8'h0F, 8'hF0, 0);
        do_op(7, 0, 8'h13, 8'h11, 0);
        do_op(6, 0, 8'h81, 8'h01, 0);
        do_op(6, 0, 8'h81, 8'h00, 0);
        do_op(0, 0, 8'h10, 8'h05, 0);
        do_op(0, 1, 8'hAA, 8'h01, 5);
        reset_mid_mul();
        do_op(0, 1, 8'h55, 8'h02, 0);

        for (int i = 0; i < 150; i++) begin
            do_op(int'($urandom_range(7, 0)), int'($urandom_range(1, 0)),
                  int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                  int'($urandom_range(2, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
